// File: rtl/nvram_ioctl_pkg.sv
// ============================================================================
// Module   : nvram_ioctl_pkg
// Purpose  : Shared types and constants for the NVRAM ioctl bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

package nvram_ioctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SLOT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam logic [7:0] NVRAM_IOCTL_INDEX = 8'd4;

endpackage : nvram_ioctl_pkg

`default_nettype wire

// File: rtl/nvram_ioctl_pause.sv
// ============================================================================
// Module   : nvram_ioctl_pause
// Purpose  : CPU pause request and end-of-download pulse for the NVRAM bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nvram_ioctl_pause (
    input  logic clk,
    input  logic reset_n,
    input  logic sel,
    input  logic download,
    input  logic index_match,
    input  logic byte_written,
    output logic cpu_pause,
    output logic load_done
);

    logic sel_q;
    logic dl_q;
    logic written;
    logic dl_now;

    assign dl_now = download && index_match;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_q     <= 1'b0;
            dl_q      <= 1'b0;
            written   <= 1'b0;
            cpu_pause <= 1'b0;
            load_done <= 1'b0;
        end else begin
            sel_q     <= sel;
            dl_q      <= dl_now;
            // Holding through sel_q keeps the core halted one extra cycle so
            // the last byte reaches memory before the CPU runs again.
            cpu_pause <= sel || sel_q;
            load_done <= dl_q && !download && index_match && written;

            if (byte_written) begin
                written <= 1'b1;
            end else if (dl_q && !dl_now) begin
                written <= 1'b0;
            end
        end
    end

endmodule : nvram_ioctl_pause

`default_nettype wire

// File: rtl/nvram_ioctl.sv
// ============================================================================
// Module   : nvram_ioctl
// Purpose  : Bridges hps_io ioctl byte transfers onto a shared NVRAM port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nvram_ioctl
    import nvram_ioctl_pkg::*;
#(
    parameter logic [7:0]  INDEX = NVRAM_IOCTL_INDEX,
    parameter int unsigned AW    = 8
) (
    input  logic          CLK_18M,
    input  logic          RESET_n,
    input  logic          ioctl_download,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic          ioctl_wr,
    input  logic          ioctl_rd,
    input  logic [7:0]    ioctl_dout,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    input  logic          mem_free,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dout,
    output logic          mem_we,
    input  logic [7:0]    mem_din,
    output logic          cpu_pause,
    output logic          load_done
);

    state_t          state;
    op_t             op;
    logic [AW-1:0]   addr_q;
    logic [7:0]      data_q;
    logic            armed;

    logic            index_match;
    logic            sel;
    logic            in_range;
    logic            idle_ready;
    logic            take_wr;
    logic            take_rd;
    logic            wr_accept;

    assign index_match = (ioctl_index == INDEX);
    assign sel         = (ioctl_download || ioctl_upload) && index_match;
    assign in_range    = ((ioctl_addr >> AW) == 25'd0);

    // The cycle right after a write slot is spent in IDLE with mem_we high;
    // strobes are not taken there because ioctl_wait is still asserted.
    assign idle_ready  = (state == ST_IDLE) && !mem_we;
    assign take_wr     = idle_ready && sel && ioctl_wr;
    assign take_rd     = idle_ready && sel && !ioctl_wr && ioctl_rd;
    assign wr_accept   = take_wr && in_range && ioctl_download;

    always_ff @(posedge CLK_18M) begin
        if (!RESET_n) begin
            state      <= ST_IDLE;
            op         <= OP_RD;
            addr_q     <= '0;
            data_q     <= 8'h00;
            armed      <= 1'b0;
            ioctl_wait <= 1'b0;
            ioctl_din  <= 8'h00;
            mem_addr   <= '0;
            mem_dout   <= 8'h00;
            mem_we     <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            case (state)
                ST_IDLE: begin
                    ioctl_wait <= 1'b0;
                    if (take_wr && in_range) begin
                        addr_q     <= ioctl_addr[AW-1:0];
                        data_q     <= ioctl_dout;
                        op         <= OP_WR;
                        ioctl_wait <= 1'b1;
                        state      <= ST_SLOT;
                    end else if (take_rd) begin
                        if (in_range) begin
                            addr_q     <= ioctl_addr[AW-1:0];
                            op         <= OP_RD;
                            ioctl_wait <= 1'b1;
                            state      <= ST_SLOT;
                        end else begin
                            ioctl_din  <= 8'h00;
                        end
                    end
                end

                ST_SLOT: begin
                    if (mem_free) begin
                        mem_addr <= addr_q;
                        if (op == OP_WR) begin
                            mem_dout <= data_q;
                            mem_we   <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            armed    <= 1'b0;
                            state    <= ST_CAPTURE;
                        end
                    end
                end

                ST_CAPTURE: begin
                    // Read data trails the presented address by one cycle.
                    if (armed) begin
                        ioctl_din  <= mem_din;
                        ioctl_wait <= 1'b0;
                        armed      <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        armed      <= 1'b1;
                    end
                end

                default: begin
                    ioctl_wait <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    nvram_ioctl_pause u_pause (
        .clk          (CLK_18M),
        .reset_n      (RESET_n),
        .sel          (sel),
        .download     (ioctl_download),
        .index_match  (index_match),
        .byte_written (wr_accept),
        .cpu_pause    (cpu_pause),
        .load_done    (load_done)
    );

endmodule : nvram_ioctl

`default_nettype wire

// File: tb/tb_nvram_ioctl.sv
// ============================================================================
// Module   : tb_nvram_ioctl
// Purpose  : Directed self-checking bench for the NVRAM ioctl bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nvram_ioctl;

    logic        CLK_18M = 1'b0;
    logic        RESET_n;
    logic        ioctl_download, ioctl_upload;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_wr, ioctl_rd;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        mem_free;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic        cpu_pause;
    logic        load_done;

    int tests = 0;
    int fails = 0;
    int we_total = 0;
    int ld_total = 0;

    logic [7:0] mem [256];

    always #5 CLK_18M = ~CLK_18M;

    nvram_ioctl #(.INDEX(8'd4), .AW(8)) dut (
        .CLK_18M        (CLK_18M),
        .RESET_n        (RESET_n),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_wr       (ioctl_wr),
        .ioctl_rd       (ioctl_rd),
        .ioctl_dout     (ioctl_dout),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .mem_free       (mem_free),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .mem_we         (mem_we),
        .mem_din        (mem_din),
        .cpu_pause      (cpu_pause),
        .load_done      (load_done)
    );

    // Synchronous-read NVRAM model.
    always @(posedge CLK_18M) begin
        if (mem_we) mem[mem_addr] <= mem_dout;
        mem_din <= mem[mem_addr];
    end

    always @(negedge CLK_18M) begin
        if (mem_we)    we_total++;
        if (load_done) ld_total++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_wr;
        logic        dl;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        int          stall;
        int          exp_wait;
        int          exp_we;
        logic        check_din;
        logic [7:0]  exp_din;
        logic        exp_pause;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input int n, input vec_t v);
        int         wait_cnt = 0;
        int         we_cnt = 0;
        logic [7:0] we_addr = 8'h00;
        logic [7:0] we_data = 8'h00;
        logic       pause_seen = 1'b0;
        @(negedge CLK_18M);
        ioctl_download = v.dl;
        ioctl_upload   = !v.dl;
        ioctl_index    = v.idx;
        ioctl_addr     = v.addr;
        ioctl_dout     = v.data;
        ioctl_wr       = v.is_wr;
        ioctl_rd       = !v.is_wr;
        mem_free       = (v.stall == 0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK_18M);
            ioctl_wr = 1'b0;
            ioctl_rd = 1'b0;
            if (ioctl_wait) wait_cnt++;
            if (cpu_pause)  pause_seen = 1'b1;
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_dout;
            end
            mem_free = (c >= v.stall);
        end
        check($sformatf("v%0d wait cycles", n), wait_cnt, v.exp_wait);
        check($sformatf("v%0d mem_we pulses", n), we_cnt, v.exp_we);
        check($sformatf("v%0d cpu_pause", n), {31'd0, pause_seen}, {31'd0, v.exp_pause});
        if (v.exp_we != 0) begin
            check($sformatf("v%0d mem_addr", n), {24'd0, we_addr}, {24'd0, v.addr[7:0]});
            check($sformatf("v%0d mem_dout", n), {24'd0, we_data}, {24'd0, v.data});
        end
        if (v.check_din)
            check($sformatf("v%0d ioctl_din", n), {24'd0, ioctl_din}, {24'd0, v.exp_din});
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        repeat (3) @(negedge CLK_18M);
    endtask

    initial begin
        int ld_snap;
        int we_snap;
        int guard;

        //          wr  dl  idx    addr          data   st  wt  we  chk din    pause
        vecs[0]  = '{1, 1, 8'd4, 25'h0000010, 8'hA5, 0,  2,  1, 0, 8'h00, 1};
        vecs[1]  = '{1, 1, 8'd4, 25'h0000020, 8'h3C, 3,  4,  1, 0, 8'h00, 1};
        vecs[2]  = '{0, 0, 8'd4, 25'h0000020, 8'h00, 10, 12, 0, 1, 8'h3C, 1};
        vecs[3]  = '{0, 0, 8'd0, 25'h0000010, 8'h00, 0,  0,  0, 1, 8'h3C, 0};
        vecs[4]  = '{1, 1, 8'd4, 25'h0000100, 8'h55, 0,  0,  0, 0, 8'h00, 1};
        vecs[5]  = '{0, 0, 8'd4, 25'h0000100, 8'h00, 0,  0,  0, 1, 8'h00, 1};
        vecs[6]  = '{0, 0, 8'd4, 25'h0000010, 8'h00, 0,  3,  0, 1, 8'hA5, 1};
        vecs[7]  = '{1, 1, 8'd0, 25'h0000030, 8'h77, 0,  0,  0, 0, 8'h00, 0};
        vecs[8]  = '{1, 1, 8'd4, 25'h00001FF, 8'h99, 0,  0,  0, 0, 8'h00, 1};
        vecs[9]  = '{1, 1, 8'd4, 25'h00000FF, 8'h81, 0,  2,  1, 0, 8'h00, 1};
        vecs[10] = '{0, 0, 8'd4, 25'h00000FF, 8'h00, 1,  3,  0, 1, 8'h81, 1};
        vecs[11] = '{0, 0, 8'd4, 25'h1000000, 8'h00, 0,  0,  0, 1, 8'h00, 1};

        RESET_n = 1'b0;
        ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
        ioctl_addr = '0; ioctl_wr = 1'b0; ioctl_rd = 1'b0; ioctl_dout = 8'h00;
        mem_free = 1'b1;
        repeat (3) @(negedge CLK_18M);
        check("reset ioctl_wait", {31'd0, ioctl_wait}, 32'd0);
        check("reset ioctl_din",  {24'd0, ioctl_din}, 32'd0);
        check("reset mem_we",     {31'd0, mem_we}, 32'd0);
        check("reset mem_addr",   {24'd0, mem_addr}, 32'd0);
        check("reset mem_dout",   {24'd0, mem_dout}, 32'd0);
        check("reset cpu_pause",  {31'd0, cpu_pause}, 32'd0);
        check("reset load_done",  {31'd0, load_done}, 32'd0);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK_18M);

        ld_snap = ld_total;
        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
        // Only downloads that wrote an in-range byte (v0, v1, v9) end with a pulse.
        check("table load_done pulses", ld_total - ld_snap, 3);

        // Reset while the write is parked in SLOT.
        we_snap = we_total;
        @(negedge CLK_18M);
        ioctl_download = 1'b1; ioctl_index = 8'd4; ioctl_addr = 25'h40;
        ioctl_dout = 8'hEE; ioctl_wr = 1'b1; mem_free = 1'b0;
        @(negedge CLK_18M);
        ioctl_wr = 1'b0;
        check("slot wait before reset", {31'd0, ioctl_wait}, 32'd1);
        RESET_n = 1'b0;
        ioctl_download = 1'b0;
        @(negedge CLK_18M);
        check("wait after mid-slot reset", {31'd0, ioctl_wait}, 32'd0);
        RESET_n = 1'b1;
        mem_free = 1'b1;
        repeat (5) @(negedge CLK_18M);
        check("no write after reset abort", we_total - we_snap, 0);
        check("wait idle after reset abort", {31'd0, ioctl_wait}, 32'd0);

        // Full 256-byte download.
        we_snap = we_total;
        ld_snap = ld_total;
        @(negedge CLK_18M);
        ioctl_download = 1'b1; ioctl_index = 8'd4;
        @(negedge CLK_18M);
        check("pause rises after one cycle", {31'd0, cpu_pause}, 32'd1);
        for (int a = 0; a < 256; a++) begin
            @(negedge CLK_18M);
            ioctl_addr = 25'(a);
            ioctl_dout = 8'(a) ^ 8'h5A;
            ioctl_wr   = 1'b1;
            @(negedge CLK_18M);
            ioctl_wr = 1'b0;
            guard = 0;
            while (ioctl_wait && guard < 50) begin
                @(negedge CLK_18M);
                guard++;
            end
            if (guard >= 50) begin
                check("download wait timeout", 32'd1, 32'd0);
                break;
            end
        end
        check("load_done not early", ld_total - ld_snap, 0);
        @(negedge CLK_18M);
        ioctl_download = 1'b0;
        @(negedge CLK_18M);
        check("pause held 1 cycle after sel falls", {31'd0, cpu_pause}, 32'd1);
        check("load_done pulse", {31'd0, load_done}, 32'd1);
        @(negedge CLK_18M);
        check("pause low 2 cycles after sel falls", {31'd0, cpu_pause}, 32'd0);
        check("load_done single cycle", {31'd0, load_done}, 32'd0);
        repeat (3) @(negedge CLK_18M);
        check("download mem_we count", we_total - we_snap, 256);
        check("download load_done count", ld_total - ld_snap, 1);
        check("mem[00]", {24'd0, mem[8'h00]}, 32'h5A);
        check("mem[FF]", {24'd0, mem[8'hFF]}, 32'hA5);
        check("mem[37]", {24'd0, mem[8'h37]}, 32'h6D);

        run_vec(12, '{0, 0, 8'd4, 25'h80, 8'h00, 0, 3, 0, 1, 8'hDA, 1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_nvram_ioctl

`default_nettype wire
